// File: rtl/instr_assembler_pkg.sv
// otter_instr_pkg: format codes, opcodes, packed result type and a sign-extension range helper.
package otter_instr_pkg;
    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } instr_fmt_t;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_REG    = 7'h33;
    typedef struct packed {
        logic [31:0] instr;
        logic        err;
    } instr_res_t;
    // True when every bit selected by mask is equal, i.e. the value is a sign extension.
    function automatic logic sext_ok(input logic [31:0] v, input logic [31:0] mask);
        return ((v & mask) == mask) || ((v & mask) == '0);
    endfunction
endpackage

// File: rtl/instr_assembler_if.sv
// instr_assembler_if: request/response handshake bundle of the instruction assembler.
interface instr_assembler_if;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_fmt;
    logic [6:0]  in_opcode;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        out_err;
    modport master (
        output in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm, out_ready,
        input  in_ready, out_valid, out_instr, out_err
    );
    modport slave (
        input  in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm, out_ready,
        output in_ready, out_valid, out_instr, out_err
    );
endinterface

// File: rtl/instr_assembler_pack.sv
// instr_pack: combinational RV32I field packing with immediate range checking.
module instr_pack
    import otter_instr_pkg::*;
(
    input  logic [2:0]  i_fmt,
    input  logic [6:0]  i_opcode,
    input  logic [4:0]  i_rd,
    input  logic [4:0]  i_rs1,
    input  logic [4:0]  i_rs2,
    input  logic [2:0]  i_funct3,
    input  logic [6:0]  i_funct7,
    input  logic [31:0] i_imm,
    output instr_res_t  o_res
);
    always_comb begin
        o_res = '0;
        case (i_fmt)
            FMT_R: o_res.instr = {i_funct7, i_rs2, i_rs1, i_funct3, i_rd, i_opcode};
            FMT_I: begin
                o_res.instr = {i_imm[11:0], i_rs1, i_funct3, i_rd, i_opcode};
                o_res.err   = !sext_ok(i_imm, 32'hFFFF_F800);
            end
            FMT_S: begin
                o_res.instr = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], i_opcode};
                o_res.err   = !sext_ok(i_imm, 32'hFFFF_F800);
            end
            FMT_B: begin
                o_res.instr = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3, i_imm[4:1], i_imm[11], i_opcode};
                o_res.err   = !sext_ok(i_imm, 32'hFFFF_F000) || i_imm[0];
            end
            FMT_U: begin
                o_res.instr = {i_imm[31:12], i_rd, i_opcode};
                o_res.err   = |i_imm[11:0];
            end
            FMT_J: begin
                o_res.instr = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, i_opcode};
                o_res.err   = !sext_ok(i_imm, 32'hFFF0_0000) || i_imm[0];
            end
            default: o_res.err = 1'b1;
        endcase
    end
endmodule

// File: rtl/instr_assembler.sv
// instr_assembler: packs RV32I instructions into a 2-entry elastic buffer and counts range errors.
module instr_assembler
    import otter_instr_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    instr_assembler_if.slave bus,
    input  logic             err_clr,
    output logic [CNT_W-1:0] err_count
);
    instr_res_t       w_res;
    instr_res_t       r_mem [2];
    logic             r_wp;
    logic             r_rp;
    logic [1:0]       r_cnt;
    logic [CNT_W-1:0] r_err_cnt;
    logic             w_push;
    logic             w_pop;
    logic             w_err_push;
    logic [CNT_W-1:0] w_err_nxt;

    instr_pack u_pack (
        .i_fmt    (bus.in_fmt),
        .i_opcode (bus.in_opcode),
        .i_rd     (bus.in_rd),
        .i_rs1    (bus.in_rs1),
        .i_rs2    (bus.in_rs2),
        .i_funct3 (bus.in_funct3),
        .i_funct7 (bus.in_funct7),
        .i_imm    (bus.in_imm),
        .o_res    (w_res)
    );

    always_comb begin
        w_push     = bus.in_valid && bus.in_ready;
        w_pop      = bus.out_valid && bus.out_ready;
        w_err_push = w_push && w_res.err;
        // A clear coinciding with an erroneous push leaves that push counted.
        w_err_nxt  = err_clr ? CNT_W'(w_err_push)
                   : (w_err_push && r_err_cnt != '1) ? r_err_cnt + CNT_W'(1) : r_err_cnt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem[0]  <= '0;
            r_mem[1]  <= '0;
            r_wp      <= 1'b0;
            r_rp      <= 1'b0;
            r_cnt     <= 2'd0;
            r_err_cnt <= '0;
        end else begin
            if (w_push) r_mem[r_wp] <= w_res;
            r_wp      <= r_wp ^ w_push;
            r_rp      <= r_rp ^ w_pop;
            r_cnt     <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
            r_err_cnt <= w_err_nxt;
        end
    end

    assign bus.in_ready  = r_cnt != 2'd2;
    assign bus.out_valid = r_cnt != 2'd0;
    assign bus.out_instr = r_mem[r_rp].instr;
    assign bus.out_err   = r_mem[r_rp].err;
    assign err_count     = r_err_cnt;
endmodule
